// File: rtl/jailbreak_hs_save_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jailbreak_hs_save_pkg
// Description : Shared types for the Jailbreak high-score save path: the
//               save FSM state encoding, the 16-bit checksum type, and a
//               saturating increment for the stable-scan counter.
// Revision    : 1.0  initial release
// ============================================================================
package jailbreak_hs_save_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GAP       = 3'd1,
        ST_SCAN      = 3'd2,
        ST_COMPARE   = 3'd3,
        ST_REQUEST   = 3'd4,
        ST_WAIT_DONE = 3'd5
    } hs_save_state_e;

    typedef logic [15:0] hs_cksum_t;

    // The signature is read first, ahead of the high-score table.
    localparam logic [8:0] c_SIG_BYTES  = 9'd3;
    localparam logic [2:0] c_STABLE_MAX = 3'd7;

    function automatic logic [2:0] hs_sat_inc(input logic [2:0] v);
        return (v == c_STABLE_MAX) ? v : v + 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hs_fletcher16.sv
`default_nettype none
// ============================================================================
// Module      : hs_fletcher16
// Description : Byte-serial Fletcher-style checksum. sum1 += byte, then
//               sum2 += (updated) sum1, both wrapping at 8 bits.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_clr         - clear both sums (priority over i_valid)
//               i_valid       - i_byte is accumulated this cycle
//               i_byte        - input byte
//               o_cksum       - {sum2, sum1}
// Revision    : 1.0  initial release
// ============================================================================
module hs_fletcher16
    import jailbreak_hs_save_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_valid,
    input  logic [7:0] i_byte,
    output hs_cksum_t  o_cksum
);

    logic [7:0] r_sum1;
    logic [7:0] r_sum2;
    logic [7:0] w_sum1_nxt;

    assign w_sum1_nxt = r_sum1 + i_byte;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_sum1 <= 8'd0;
            r_sum2 <= 8'd0;
        end else if (i_valid) begin
            r_sum1 <= w_sum1_nxt;
            r_sum2 <= r_sum2 + w_sum1_nxt;
        end
    end

    assign o_cksum = {r_sum2, r_sum1};

endmodule
`default_nettype wire

// File: rtl/jailbreak_hs_save.sv
`default_nettype none
// ============================================================================
// Module      : jailbreak_hs_save
// Description : Periodically scans the Jailbreak high-score RAM, checks the
//               game signature, and raises a flush request once the table
//               checksum has changed and held the same new value for
//               STABLE_SCANS consecutive scans.
// Ports       : clk, reset            - core clock, sync active-high reset
//               arm                   - restore done / signature seen (level)
//               scan_en               - RAM port granted to this block
//               hs_address/hs_data_out- RAM byte port, 1-cycle read latency
//               flush_valid/ready     - flush request handshake
//               flush_slot_id/size    - request fields, zero when idle
//               flush_done            - host read complete pulse
//               flush_count           - accepted flushes, wrapping
// Revision    : 1.0  initial release
// ============================================================================
module jailbreak_hs_save
    import jailbreak_hs_save_pkg::*;
#(
    parameter logic [15:0] HISCORE_SLOT_ID = 16'd2,
    parameter logic [11:0] HISCORE_BASE    = 12'h620,
    parameter logic [7:0]  HISCORE_SIZE    = 8'h50,
    parameter logic [11:0] CHECK_ADDR      = 12'h57e,
    parameter logic [23:0] CHECK_VALUE     = 24'h302500,
    parameter logic [2:0]  STABLE_SCANS    = 3'd4,
    parameter logic [23:0] SCAN_GAP        = 24'd1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arm,
    input  logic        scan_en,
    output logic [11:0] hs_address,
    input  logic [7:0]  hs_data_out,
    output logic        flush_valid,
    input  logic        flush_ready,
    output logic [15:0] flush_slot_id,
    output logic [31:0] flush_size,
    input  logic        flush_done,
    output logic [7:0]  flush_count
);

    // Number of addresses per scan; r_idx reaches this value on the cycle the
    // last byte is captured.
    localparam logic [8:0] c_SCAN_LEN = {1'b0, HISCORE_SIZE} + c_SIG_BYTES;

    hs_save_state_e r_state;
    hs_save_state_e w_state_nxt;

    logic [8:0]  r_idx;
    logic [23:0] r_gap;
    logic [23:0] r_sig;
    hs_cksum_t   r_base;
    hs_cksum_t   r_cand;
    hs_cksum_t   w_cksum;
    logic        r_base_vld;
    logic        r_cand_vld;
    logic [2:0]  r_stable;
    logic [7:0]  r_flush_cnt;

    logic        w_disarm;
    logic        w_enter_scan;
    logic        w_cap_sig;
    logic        w_cap_hs;
    logic        w_sig_ok;
    logic        w_changed;
    logic        w_repeat;
    logic [2:0]  w_stable_nxt;

    // WAIT_DONE must see the host read through even if arm drops.
    assign w_disarm     = !arm && (r_state != ST_WAIT_DONE);
    assign w_enter_scan = (w_state_nxt == ST_SCAN) && (r_state != ST_SCAN);

    // In SCAN, r_idx = k means address k is on the bus and the data for
    // address k-1 is on hs_data_out.
    assign w_cap_sig = (r_state == ST_SCAN) && (r_idx != 9'd0) && (r_idx <= c_SIG_BYTES);
    assign w_cap_hs  = (r_state == ST_SCAN) && (r_idx >  c_SIG_BYTES);

    assign w_sig_ok     = (r_sig == CHECK_VALUE);
    assign w_changed    = (w_cksum != r_base);
    assign w_repeat     = r_cand_vld && (w_cksum == r_cand);
    assign w_stable_nxt = w_repeat ? hs_sat_inc(r_stable) : 3'd1;

    hs_fletcher16 u_fletcher (
        .clk     (clk),
        .rst     (reset),
        .i_clr   (w_enter_scan),
        .i_valid (w_cap_hs),
        .i_byte  (hs_data_out),
        .o_cksum (w_cksum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        hs_address    = CHECK_ADDR;
        flush_valid   = (r_state == ST_REQUEST);
        flush_slot_id = 16'd0;
        flush_size    = 32'd0;

        if (w_disarm) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:      w_state_nxt = ST_SCAN;
                ST_GAP: begin
                    if ((r_gap + 24'd1) >= SCAN_GAP) w_state_nxt = ST_SCAN;
                end
                ST_SCAN: begin
                    if (!scan_en)                    w_state_nxt = ST_GAP;
                    else if (r_idx == c_SCAN_LEN)    w_state_nxt = ST_COMPARE;
                end
                ST_COMPARE: begin
                    if (w_sig_ok && r_base_vld && w_changed && (w_stable_nxt >= STABLE_SCANS))
                        w_state_nxt = ST_REQUEST;
                    else
                        w_state_nxt = ST_GAP;
                end
                ST_REQUEST: begin
                    if (flush_ready) w_state_nxt = ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (flush_done) w_state_nxt = ST_GAP;
                end
                default:      w_state_nxt = ST_IDLE;
            endcase
        end

        if (r_state == ST_SCAN) begin
            if (r_idx < c_SIG_BYTES)
                hs_address = CHECK_ADDR + 12'(r_idx);
            else if (r_idx < c_SCAN_LEN)
                hs_address = HISCORE_BASE + 12'(r_idx - c_SIG_BYTES);
        end

        if (r_state == ST_REQUEST) begin
            flush_slot_id = HISCORE_SLOT_ID;
            flush_size    = {24'd0, HISCORE_SIZE};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx       <= 9'd0;
            r_gap       <= 24'd0;
            r_sig       <= 24'd0;
            r_base      <= '0;
            r_base_vld  <= 1'b0;
            r_cand      <= '0;
            r_cand_vld  <= 1'b0;
            r_stable    <= 3'd0;
            r_flush_cnt <= 8'd0;
        end else begin
            r_idx <= (r_state == ST_SCAN) ? r_idx + 9'd1 : 9'd0;
            r_gap <= (r_state == ST_GAP)  ? r_gap + 24'd1 : 24'd0;

            if (w_enter_scan)
                r_sig <= 24'd0;
            else if (w_cap_sig)
                r_sig <= {hs_data_out, r_sig[23:8]};

            if (w_disarm) begin
                // Re-arming relearns the table from scratch.
                r_base_vld <= 1'b0;
                r_cand_vld <= 1'b0;
                r_stable   <= 3'd0;
            end else if (r_state == ST_COMPARE) begin
                if (!w_sig_ok) begin
                    r_stable <= 3'd0;
                end else if (!r_base_vld) begin
                    r_base     <= w_cksum;
                    r_base_vld <= 1'b1;
                end else if (!w_changed) begin
                    r_stable <= 3'd0;
                end else begin
                    r_stable <= w_stable_nxt;
                    if (!w_repeat) begin
                        r_cand     <= w_cksum;
                        r_cand_vld <= 1'b1;
                    end
                end
            end else if ((r_state == ST_REQUEST) && flush_ready) begin
                r_base      <= r_cand;
                r_flush_cnt <= r_flush_cnt + 8'd1;
                r_stable    <= 3'd0;
            end
        end
    end

    assign flush_count = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_jailbreak_hs_save.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_jailbreak_hs_save
// Description : Scoreboard bench for jailbreak_hs_save. Expected flush
//               requests (fields, flush_count before acceptance, and the
//               completed-scan number at which they appear) are queued by the
//               stimulus; a negedge monitor pops one whenever flush_valid
//               rises. A RAM model serves reads with 1-cycle latency.
// Revision    : 1.0  initial release
// ============================================================================
module tb_jailbreak_hs_save;

    localparam logic [15:0] c_SLOT = 16'd2;
    localparam logic [11:0] c_BASE = 12'h620;
    localparam logic [7:0]  c_SIZE = 8'h50;
    localparam logic [11:0] c_CHK  = 12'h57e;
    localparam logic [23:0] c_GAP  = 24'd10;
    localparam logic [11:0] c_LAST = 12'h66f;

    logic        clk = 1'b0;
    logic        reset;
    logic        arm;
    logic        scan_en;
    logic [11:0] hs_address;
    logic [7:0]  hs_data_out = 8'h00;
    logic        flush_valid;
    logic        flush_ready;
    logic [15:0] flush_slot_id;
    logic [31:0] flush_size;
    logic        flush_done;
    logic [7:0]  flush_count;

    logic [7:0]  mem [0:4095];

    typedef struct {
        logic [15:0] slot;
        logic [31:0] size;
        logic [7:0]  cnt;
        int          scan;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   scan_cnt = 0;
    int   last_addr_cyc = -100;
    logic prev_valid = 1'b0;

    jailbreak_hs_save #(
        .HISCORE_SLOT_ID (16'd2),
        .HISCORE_BASE    (12'h620),
        .HISCORE_SIZE    (8'h50),
        .CHECK_ADDR      (12'h57e),
        .CHECK_VALUE     (24'h302500),
        .STABLE_SCANS    (3'd4),
        .SCAN_GAP        (c_GAP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .arm           (arm),
        .scan_en       (scan_en),
        .hs_address    (hs_address),
        .hs_data_out   (hs_data_out),
        .flush_valid   (flush_valid),
        .flush_ready   (flush_ready),
        .flush_slot_id (flush_slot_id),
        .flush_size    (flush_size),
        .flush_done    (flush_done),
        .flush_count   (flush_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        hs_data_out <= mem[hs_address];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: counts completed scans and scores every flush presentation.
    always @(negedge clk) begin
        if (hs_address == c_LAST) begin
            scan_cnt++;
            last_addr_cyc = cyc;
        end
        if (flush_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_flush", {31'd0, flush_valid}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("flush_slot_id", {16'd0, flush_slot_id}, {16'd0, e.slot});
                chk("flush_size", flush_size, e.size);
                chk("flush_count_at_req", {24'd0, flush_count}, {24'd0, e.cnt});
                chk("flush_scan_no", scan_cnt, e.scan);
                chk("flush_latency", cyc - last_addr_cyc, 32'd3);
            end
        end
        prev_valid = flush_valid;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_scans(input int target);
        int budget;
        budget = (target - scan_cnt) * 150 + 200;
        while (scan_cnt < target && budget > 0) begin
            step(1);
            budget--;
        end
        chk("scans_reached", {31'd0, scan_cnt >= target}, 32'd1);
    endtask

    task automatic wait_flush();
        int budget;
        budget = 20;
        while (!flush_valid && budget > 0) begin
            step(1);
            budget--;
        end
        chk("flush_seen", {31'd0, flush_valid}, 32'd1);
    endtask

    task automatic accept(input logic [7:0] cnt_after);
        flush_ready = 1'b1;
        step(1);
        flush_ready = 1'b0;
        chk("valid_drop", {31'd0, flush_valid}, 32'd0);
        chk("flush_count", {24'd0, flush_count}, {24'd0, cnt_after});
    endtask

    task automatic finish_done();
        int bad;
        bad = 0;
        repeat (30) begin
            step(1);
            if (hs_address != c_CHK) bad++;
        end
        chk("wait_done_no_scan", bad, 32'd0);
        flush_done = 1'b1;
        step(1);
        flush_done = 1'b0;
    endtask

    task automatic expect_flush(input logic [7:0] cnt, input int scan);
        exp_q.push_back('{slot: c_SLOT, size: {24'd0, c_SIZE}, cnt: cnt, scan: scan});
    endtask

    task automatic chk_reset_outputs();
        chk("rst_addr",  {20'd0, hs_address}, {20'd0, c_CHK});
        chk("rst_valid", {31'd0, flush_valid}, 32'd0);
        chk("rst_count", {24'd0, flush_count}, 32'd0);
        chk("rst_slot",  {16'd0, flush_slot_id}, 32'd0);
        chk("rst_size",  flush_size, 32'd0);
    endtask

    initial begin
        int budget;
        int bad;
        reset       = 1'b1;
        arm         = 1'b0;
        scan_en     = 1'b1;
        flush_ready = 1'b0;
        flush_done  = 1'b0;
        for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
        mem[12'h57e] = 8'h00;
        mem[12'h57f] = 8'h25;
        mem[12'h580] = 8'h30;
        for (int i = 0; i < 80; i++) mem[c_BASE + 12'(i)] = 8'(i * 3 + 1);

        step(3);
        chk_reset_outputs();
        reset = 1'b0;
        step(2);
        chk("idle_addr", {20'd0, hs_address}, {20'd0, c_CHK});

        // Static table: baseline only, ready asserted with nothing to accept.
        flush_ready = 1'b1;
        arm         = 1'b1;
        wait_scans(10);
        step(4);
        flush_ready = 1'b0;
        chk("count_static", {24'd0, flush_count}, 32'd0);

        // One byte change: flush on the 4th identical changed scan.
        mem[c_BASE] = 8'h55;
        expect_flush(8'd0, 14);
        wait_scans(14);
        wait_flush();
        accept(8'd1);
        mem[c_BASE + 12'd1] = 8'hAA;
        finish_done();

        // Second change after two scans restarts the stable count.
        wait_scans(16);
        step(4);
        mem[c_BASE + 12'd2] = 8'h11;
        expect_flush(8'd1, 20);
        wait_scans(20);
        wait_flush();
        accept(8'd2);
        finish_done();

        // Corrupt signature after re-arm: no baseline, table change ignored.
        step(3);
        arm = 1'b0;
        step(3);
        mem[12'h580] = 8'h31;
        arm = 1'b1;
        wait_scans(22);
        step(4);
        mem[c_BASE + 12'd3] = 8'h77;
        wait_scans(28);
        step(4);
        mem[12'h580] = 8'h30;
        wait_scans(29);
        step(4);
        mem[c_BASE + 12'd4] = 8'h20;
        expect_flush(8'd2, 33);
        wait_scans(33);
        wait_flush();
        accept(8'd3);
        mem[c_BASE + 12'd5] = 8'h99;
        finish_done();

        // Abort the third changed scan at cycle 40 via scan_en.
        wait_scans(35);
        expect_flush(8'd3, 37);
        budget = 200;
        while (hs_address != (c_CHK + 12'd1) && budget > 0) begin
            step(1);
            budget--;
        end
        chk("scan_start", {20'd0, hs_address}, {20'd0, c_CHK + 12'd1});
        step(39);
        chk("addr_cycle40", {20'd0, hs_address}, {20'd0, c_BASE + 12'd37});
        scan_en = 1'b0;
        step(1);
        chk("abort_addr", {20'd0, hs_address}, {20'd0, c_CHK});
        step(3);
        scan_en = 1'b1;
        wait_scans(37);
        wait_flush();

        // Back-pressure: request must hold steady.
        bad = 0;
        repeat (50) begin
            step(1);
            if (!flush_valid || flush_slot_id != c_SLOT || flush_size != {24'd0, c_SIZE}) bad++;
        end
        chk("hold_stable", bad, 32'd0);
        accept(8'd4);
        mem[c_BASE + 12'd6] = 8'h42;
        finish_done();

        // Reset while a request is pending.
        expect_flush(8'd4, 41);
        wait_scans(41);
        wait_flush();
        step(5);
        reset = 1'b1;
        step(1);
        chk_reset_outputs();
        reset = 1'b0;
        arm   = 1'b0;
        step(3);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
